// File: rtl/shop_cmd_arbiter.sv
// Round-robin arbiter sharing the shop core command port between terminals.
// Tracks Login/Logout session locks with an idle timeout on the lock owner.
module shop_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_BITS = 56,
  parameter int U_BITS = 4,
  parameter int O_BITS = 72,
  parameter int RESP_LAT = 3,
  parameter int LOCK_TIMEOUT = 16,
  parameter logic [A_BITS-1:0] CMD_KEY__LOGIN = A_BITS'("Login"),
  parameter logic [A_BITS-1:0] CMD_KEY__LOGOUT = A_BITS'("Logout")
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*U_BITS-1:0]  i_req_u,
  input  logic [NUM_REQ*A_BITS-1:0]  i_req_a,
  output logic [NUM_REQ-1:0]         o_ack,
  output logic [O_BITS-1:0]          o_resp_a,
  output logic                       o_shop_rdy,
  output logic [U_BITS-1:0]          o_shop_u,
  output logic [A_BITS-1:0]          o_shop_a,
  input  logic [O_BITS-1:0]          i_shop_a,
  output logic                       o_busy,
  output logic                       o_lock_valid,
  output logic [2:0]                 o_lock_owner
);

  localparam int CW = $clog2(RESP_LAT) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  logic [2:0]        rr_ptr;
  logic [2:0]        grant;
  logic [CW-1:0]     cnt;
  logic [TW-1:0]     idle_tmr;

  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] elig;
  logic               owner_req;
  logic               found;
  logic [2:0]         pick;
  logic [U_BITS-1:0]  u_sel;
  logic [A_BITS-1:0]  a_sel;
  int                 j_c;

  assign owner_mask = ONE << o_lock_owner;
  assign owner_req  = |(i_req & owner_mask);
  assign elig       = o_lock_valid ? (i_req & owner_mask) : i_req;
  assign o_busy     = (state != S_IDLE);

  // first eligible index scanning upward from rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j_c   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j_c = int'(rr_ptr) + i;
      if (j_c >= NUM_REQ) j_c = j_c - NUM_REQ;
      if (!found && ((elig >> j_c) & ONE) != '0) begin
        found = 1'b1;
        pick  = 3'(j_c);
      end
    end
    u_sel = U_BITS'(i_req_u >> (int'(pick) * U_BITS));
    a_sel = A_BITS'(i_req_a >> (int'(pick) * A_BITS));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      cnt          <= '0;
      idle_tmr     <= '0;
      o_ack        <= '0;
      o_resp_a     <= '0;
      o_shop_rdy   <= 1'b0;
      o_shop_u     <= '0;
      o_shop_a     <= '0;
      o_lock_valid <= 1'b0;
      o_lock_owner <= '0;
    end else begin
      o_shop_rdy <= 1'b0;
      o_ack      <= '0;
      unique case (state)
        S_IDLE: begin
          if (o_lock_valid) begin
            if (owner_req) begin
              idle_tmr <= '0;
            end else if (idle_tmr == TW'(LOCK_TIMEOUT - 1)) begin
              o_lock_valid <= 1'b0;
              o_lock_owner <= '0;
              idle_tmr     <= '0;
            end else begin
              idle_tmr <= idle_tmr + 1'b1;
            end
          end
          if (found) begin
            grant      <= pick;
            o_shop_u   <= u_sel;
            o_shop_a   <= a_sel;
            rr_ptr     <= (pick == 3'(NUM_REQ - 1)) ? 3'd0 : pick + 3'd1;
            o_shop_rdy <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= CW'(RESP_LAT - 1);
          state <= S_WAIT;
          if (o_shop_a == CMD_KEY__LOGIN && !o_lock_valid) begin
            o_lock_valid <= 1'b1;
            o_lock_owner <= grant;
            idle_tmr     <= '0;
          end else if (o_shop_a == CMD_KEY__LOGOUT && o_lock_valid &&
                       grant == o_lock_owner) begin
            o_lock_valid <= 1'b0;
            o_lock_owner <= '0;
            idle_tmr     <= '0;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            o_resp_a <= i_shop_a;
            o_ack    <= ONE << grant;
            state    <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shop_cmd_arbiter.md
Name: shop_cmd_arbiter

Overview:
- Shares the single command port of the shop database core between NUM_REQ front-end terminals.
- Grants one requester at a time, round-robin, and drives the shop's rdy/u/a handshake.
- Captures the shop's ASCII response and returns it to the granted requester.
- Enforces session ownership: after a Login, only that requester is served until it issues Logout or its lock times out.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- A_BITS, 56: width of the ASCII command field (7 chars x 8).
- U_BITS, 4: width of the user id.
- O_BITS, 72: width of the ASCII response (9 chars x 8).
- RESP_LAT, 3: clocks from shop rdy pulse to valid shop response, >=1.
- LOCK_TIMEOUT, 16: idle IDLE-state cycles before a session lock is dropped.
- CMD_KEY__LOGIN, "Login": command string that sets the lock.
- CMD_KEY__LOGOUT, "Logout": command string that clears the lock.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_REQ  per-requester command request, held until ack.
- i_req_u  in  NUM_REQ*U_BITS  packed user ids; requester k at [k*U_BITS +: U_BITS].
- i_req_a  in  NUM_REQ*A_BITS  packed ASCII commands; same packing scheme.
- o_ack  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- o_resp_a  out  O_BITS  response; valid only while o_ack != 0.
- o_shop_rdy  out  1  command strobe to the shop core.
- o_shop_u  out  U_BITS  user id to the shop core.
- o_shop_a  out  A_BITS  command to the shop core.
- i_shop_a  in  O_BITS  shop core response.
- o_busy  out  1  high in every state except IDLE.
- o_lock_valid  out  1  a session lock is held.
- o_lock_owner  out  3  index of the lock owner; 0 when no lock is held.

Behaviour:
- Reset (async, i_reset_n=0): state=IDLE; rr_ptr=0; lock cleared; idle timer=0; all outputs 0. Asserting reset mid-transaction drops o_shop_rdy immediately, and the transaction is lost with no ack.
- Eligible set: if a lock is held, i_req[owner] only; otherwise all of i_req.
- IDLE:
  - If any requester is eligible, grant the first eligible index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register that requester's u and a into o_shop_u and o_shop_a, set rr_ptr=grant+1 mod NUM_REQ, and go to ISSUE.
  - If none is eligible, stay in IDLE.
- ISSUE: o_shop_rdy=1 for exactly 1 cycle; next state is WAIT with cnt=RESP_LAT-1.
- WAIT: decrement cnt. When cnt==0, register i_shop_a into o_resp_a and go to RESP.
- RESP: o_ack[grant]=1 for 1 cycle, then IDLE.
- Latency: a request sampled in IDLE at edge t produces o_shop_rdy in cycle t+1 and o_ack in cycle t+2+RESP_LAT. Back-to-back throughput is one command per RESP_LAT+3 cycles.
- o_shop_u and o_shop_a hold their value until the next grant. o_resp_a holds its value after the ack, but is defined only during the ack.
- Requester protocol:
  - Hold i_req, u and a stable until the ack.
  - Deassert i_req in the cycle after the ack, or keep it high to issue the next command.
  - Dropping i_req after the grant does not abort the transaction; the ack still pulses.
- Lock update, applied on the ISSUE edge using the latched command:
  - If a == CMD_KEY__LOGIN (full A_BITS compare, string zero-padded on the left) and no lock is held: lock_valid=1, owner=grant.
  - If a == CMD_KEY__LOGOUT and grant == owner: lock cleared.
  - Login from the current owner leaves the lock unchanged.
- Timeout:
  - While the lock is held, the arbiter is in IDLE, and i_req[owner]=0, the idle timer increments each cycle.
  - The timer resets to 0 on any grant to the owner or when the lock clears.
  - When the timer reaches LOCK_TIMEOUT-1, the lock clears on the next edge.
  - Non-owner requests wait, with no ack, while the lock is held.
- Simultaneous events: if the timeout expiry and an owner request land on the same edge, the owner is granted and the lock is kept.

Test Plan:
- Reset, then i_req=4'b0101 with commands "Buy" → first ack to requester 0 at cycle t+5 (RESP_LAT=3), next grant to requester 2; rr_ptr ends at 3.
- All four requesting "Buy" continuously → acks in order 0,1,2,3,0 at 6-cycle spacing, and o_shop_rdy is high for exactly 1 cycle per command.
- Requester 1 sends "Login" → o_lock_valid=1, o_lock_owner=1. Requesters 0 and 2 then request and get no ack while requester 1 issues "AddItem". After requester 1 sends "Logout", the lock clears and requesters 2 and 0 are served.
- Locked to requester 3, owner idle → lock clears after 16 idle cycles, and waiting requester 0 is granted on the following edge.
- Shop drives i_shop_a="InvalCmd" → o_resp_a equals "InvalCmd" (zero-padded to 72 bits) during o_ack[grant].
- Reset asserted during WAIT → all outputs 0 asynchronously, no ack. After release, a pending request is re-granted from rr_ptr=0.
